// File: rtl/feature_map_streamer.sv
// feature_map_streamer: streams a stored feature map from single-port RAM, row-major, with optional zero padding
//   clk, rst         : clock, synchronous active-high reset
//   start, hold      : frame request (IDLE only), issue stall (RUN only)
//   mem_rd_en/addr   : registered RAM read strobe and address
//   mem_rd_data      : RAM data, valid the cycle after mem_rd_en
//   dout, dout_vld   : registered pixel stream, 2 cycles after each issue
//   busy, done       : frame in progress, one-cycle pulse on the final pixel
module feature_map_streamer #(
    parameter int width  = 8,
    parameter int img_w  = 28,
    parameter int img_h  = 28,
    parameter int pad    = 0,
    parameter int addr_w = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    output logic              mem_rd_en,
    output logic [addr_w-1:0] mem_addr,
    input  logic [width-1:0]  mem_rd_data,
    output logic [width-1:0]  dout,
    output logic              dout_vld,
    output logic              busy,
    output logic              done
);
    localparam int PW = img_w + 2 * pad;
    localparam int PH = img_h + 2 * pad;
    localparam int CW = $clog2((PW > PH ? PW : PH) + 1);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state;
    logic [CW-1:0] row, col, cur_row, cur_col, nxt_row, nxt_col;
    logic [31:0] rr, cr;
    logic [addr_w-1:0] addr_full;
    logic issue, interior, last, col_end;
    logic v1, p1, l1, v2, p2, l2;
    // The accepting start cycle already issues position (0,0), so the first read lands one cycle later.
    always_comb begin
        issue     = state == IDLE ? start : (state == RUN && !hold);
        cur_row   = state == IDLE ? '0 : row;
        cur_col   = state == IDLE ? '0 : col;
        // Underflow on border rows/cols makes these huge, so one unsigned compare covers both sides.
        rr        = 32'(cur_row) - 32'(pad);
        cr        = 32'(cur_col) - 32'(pad);
        interior  = rr < 32'(img_h) && cr < 32'(img_w);
        addr_full = addr_w'(rr * 32'(img_w) + cr);
        col_end   = cur_col == CW'(PW - 1);
        last      = col_end && cur_row == CW'(PH - 1);
        nxt_col   = col_end ? '0 : cur_col + CW'(1);
        nxt_row   = col_end ? cur_row + CW'(1) : cur_row;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            v1        <= 1'b0;
            p1        <= 1'b0;
            l1        <= 1'b0;
            v2        <= 1'b0;
            p2        <= 1'b0;
            l2        <= 1'b0;
            dout      <= '0;
            dout_vld  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (issue) begin
                row      <= nxt_row;
                col      <= nxt_col;
                mem_addr <= interior ? addr_full : mem_addr;
            end
            mem_rd_en <= issue && interior;
            v1        <= issue;
            p1        <= !interior;
            l1        <= issue && last;
            v2        <= v1;
            p2        <= p1;
            l2        <= l1;
            dout_vld  <= v2;
            if (v2)
                dout <= p2 ? '0 : mem_rd_data;
            done  <= v2 && l2;
            busy  <= (state == IDLE && start) ? 1'b1 : done ? 1'b0 : busy;
            // DRAIN lasts until the final pixel's done pulse, so IDLE resumes the cycle after it.
            state <= issue ? (last ? DRAIN : RUN) : (state == DRAIN && done) ? IDLE : state;
        end
    end
endmodule

// File: tb/tb_feature_map_streamer.sv
// tb_feature_map_streamer: scoreboard bench for feature_map_streamer in 4x3, padded 4x3 and 28x28 configurations
module tb_feature_map_streamer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic start_a = 1'b0, hold_a = 1'b0, start_b = 1'b0, hold_b = 1'b0, start_c = 1'b0, hold_c = 1'b0;
    logic rd_a, rd_b, rd_c, vld_a, vld_b, vld_c, busy_a, busy_b, busy_c, done_a, done_b, done_c;
    logic [3:0] addr_a, addr_b;
    logic [9:0] addr_c;
    logic [7:0] rdata_a, rdata_b, rdata_c, dout_a, dout_b, dout_c;
    int total = 0;
    int bad = 0;
    int qa[$], qb[$], qc[$];

    feature_map_streamer #(.width(8), .img_w(4), .img_h(3), .pad(0), .addr_w(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .hold(hold_a), .mem_rd_en(rd_a), .mem_addr(addr_a),
        .mem_rd_data(rdata_a), .dout(dout_a), .dout_vld(vld_a), .busy(busy_a), .done(done_a));
    feature_map_streamer #(.width(8), .img_w(4), .img_h(3), .pad(1), .addr_w(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .hold(hold_b), .mem_rd_en(rd_b), .mem_addr(addr_b),
        .mem_rd_data(rdata_b), .dout(dout_b), .dout_vld(vld_b), .busy(busy_b), .done(done_b));
    feature_map_streamer #(.width(8), .img_w(28), .img_h(28), .pad(0), .addr_w(10)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .hold(hold_c), .mem_rd_en(rd_c), .mem_addr(addr_c),
        .mem_rd_data(rdata_c), .dout(dout_c), .dout_vld(vld_c), .busy(busy_c), .done(done_c));

    // RAM models: RAM[i]=i+1 for the small maps, RAM[i]=i mod 256 for the large one
    always @(posedge clk) begin
        if (rd_a) rdata_a <= 8'(addr_a + 4'd1);
        if (rd_b) rdata_b <= 8'(addr_b + 4'd1);
        if (rd_c) rdata_c <= addr_c[7:0];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (vld_a === 1'b1) begin
            check("a_queue_nonempty", qa.size() > 0, 1);
            if (qa.size() > 0) check("a_dout", dout_a, qa.pop_front());
            if (done_a) check("a_done_last", qa.size(), 0);
        end
        if (vld_b === 1'b1) begin
            check("b_queue_nonempty", qb.size() > 0, 1);
            if (qb.size() > 0) check("b_dout", dout_b, qb.pop_front());
            if (done_b) check("b_done_last", qb.size(), 0);
        end
        if (vld_c === 1'b1) begin
            check("c_queue_nonempty", qc.size() > 0, 1);
            if (qc.size() > 0) check("c_dout", dout_c, qc.pop_front());
            if (done_c) check("c_done_last", qc.size(), 0);
        end
    end

    // One 4x3 frame on dut_a; called just after a rising edge, which becomes cycle 0.
    task automatic run_a(input logic [31:0] hmask, input logic [31:0] smask);
        int ic[12];
        int n, dc, ea;
        logic ev, er;
        logic [7:0] lastv;
        n = 1;
        ic[0] = 0;
        for (int c = 1; n < 12 && c < 32; c++)
            if (!hmask[c]) begin
                ic[n] = c;
                n++;
            end
        dc = ic[11] + 3;
        for (int i = 1; i <= 12; i++) qa.push_back(i);
        lastv = 0;
        start_a = 1'b1;
        hold_a = hmask[0];
        @(posedge clk); #1;
        for (int c = 1; c <= dc; c++) begin
            start_a = smask[c];
            hold_a = hmask[c];
            ev = 0;
            er = 0;
            ea = 0;
            for (int j = 0; j < 12; j++) begin
                if (ic[j] + 3 == c) ev = 1;
                if (ic[j] + 1 == c) begin
                    er = 1;
                    ea = j;
                end
            end
            @(negedge clk);
            check("a_vld", vld_a, ev);
            check("a_rd_en", rd_a, er);
            if (er) check("a_addr", addr_a, ea);
            check("a_busy", busy_a, 1);
            check("a_done", done_a, c == dc);
            if (!ev && c > 3) check("a_gap_dout", dout_a, lastv);
            lastv = dout_a;
            @(posedge clk); #1;
        end
        start_a = 1'b0;
        hold_a = 1'b0;
    endtask

    initial begin
        int rdn, la;
        repeat (3) @(posedge clk);
        #1;
        start_a = 1'b1;
        @(negedge clk);
        check("rst_dout", dout_a, 0);
        check("rst_vld", vld_a, 0);
        check("rst_rd_en", rd_a, 0);
        check("rst_addr", addr_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        start_a = 1'b0;
        @(negedge clk);
        check("rst_start_lost_busy", busy_a, 0);
        check("rst_start_lost_rd", rd_a, 0);
        @(posedge clk); #1;
        // plain frame, with a start in the done cycle that must be ignored
        run_a(32'h0, 32'h4000);
        // immediate restart in cycle 15; holds in 3,4,8 and a stray start in 5
        run_a(32'h118, 32'h20);
        repeat (3) @(posedge clk);
        #1;
        // mid-frame reset in cycle 6
        for (int i = 1; i <= 12; i++) qa.push_back(i);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        qa.delete();
        @(negedge clk);
        check("mrst_dout", dout_a, 0);
        check("mrst_vld", vld_a, 0);
        check("mrst_rd_en", rd_a, 0);
        check("mrst_addr", addr_a, 0);
        check("mrst_busy", busy_a, 0);
        check("mrst_done", done_a, 0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("mrst_no_done", done_a, 0);
            check("mrst_no_vld", vld_a, 0);
        end
        @(posedge clk); #1;
        run_a(32'h0, 32'h0);
        // padded 6x5 frame
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 6; c++)
                qb.push_back((r >= 1 && r <= 3 && c >= 1 && c <= 4) ? (r - 1) * 4 + c : 0);
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        rdn = 0;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            check("b_vld", vld_b, c >= 3);
            check("b_done", done_b, c == 32);
            if (rd_b) begin
                rdn++;
                check("b_addr_range", addr_b < 12, 1);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("b_busy_end", busy_b, 0);
        check("b_rd_count", rdn, 12);
        check("b_queue_empty", qb.size(), 0);
        @(posedge clk); #1;
        // full 28x28 frame
        for (int i = 0; i < 784; i++) qc.push_back(i % 256);
        start_c = 1'b1;
        @(posedge clk); #1;
        start_c = 1'b0;
        la = -1;
        for (int c = 1; c <= 786; c++) begin
            @(negedge clk);
            check("c_vld", vld_c, c >= 3);
            check("c_done", done_c, c == 786);
            if (rd_c) la = int'(addr_c);
            @(posedge clk); #1;
        end
        check("c_last_addr", la, 783);
        check("c_queue_empty", qc.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/feature_map_streamer.md
# feature_map_streamer

Producer side of the line-buffer/shift-register window path: reads one stored feature map from a synchronous single-port RAM in row-major order and streams it, one pixel per cycle, as a `dout`/`dout_vld` stream. Optional zero padding is inserted on the fly, so downstream shift registers see a complete padded frame. Sits between the layer output buffers and the convolution window shift registers; `dout`/`dout_vld` connect directly to their `din`/`input_vld`.

## Interface
- `width`, 8: pixel bit width.
- `img_w`, 28: stored feature-map columns.
- `img_h`, 28: stored feature-map rows.
- `pad`, 0: zero border width on every side (0..3).
- `addr_w`, 10: RAM address width; must satisfy 2^addr_w >= img_w*img_h.

Ports:
- `clk` in 1: the single clock; everything is on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: frame request; sampled only in IDLE.
- `hold` in 1: when high in RUN, no new position is issued that cycle.
- `mem_rd_en` out 1: RAM read strobe (registered).
- `mem_addr` out addr_w: RAM read address (registered).
- `mem_rd_data` in width: RAM data, valid the cycle after `mem_rd_en`.
- `dout` out width: streamed pixel (registered).
- `dout_vld` out 1: `dout` valid this cycle.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse on the final output.

## Operation
- Padded frame: PW = img_w+2*pad columns, PH = img_h+2*pad rows, N = PW*PH positions, scanned row-major.
- Counters: `col` (0..PW-1) and `row` (0..PH-1). `col` wraps to 0 and increments `row`.
- FSM states:
  - IDLE: `start`=1 goes to RUN, with counters cleared.
  - RUN: each cycle with `hold`=0 issues position (row,col) and advances. Issuing position N-1 goes to DRAIN.
  - DRAIN: waits 2 cycles for the pipeline to empty, then goes to IDLE.
- Issue rule:
  - Interior position (pad <= row < pad+img_h and pad <= col < pad+img_w): next cycle `mem_rd_en`=1, `mem_addr`=(row-pad)*img_w+(col-pad).
  - Border position: `mem_rd_en`=0, `mem_addr` holds its value, and a pad flag enters the pipeline.
- Two-stage valid/pad pipeline tracks each issue. At stage 2: `dout_vld`=1 and `dout` = pad ? 0 : `mem_rd_data`.
- When `dout_vld`=0, `dout` holds its last value.
- `hold`:
  - Only stalls issuing; positions already in flight still emerge, so `dout_vld` shows gaps.
  - Ignored in IDLE and DRAIN.
- `start` while `busy`=1 is ignored. No queuing.
- `busy` is 1 from the cycle after `start` is accepted through the `done` cycle, inclusive.
- `done`=1 exactly with the N-th `dout_vld`.

## Timing
- Reset values: `dout`=0, `dout_vld`=0, `mem_rd_en`=0, `mem_addr`=0, `busy`=0, `done`=0. FSM in IDLE, counters and pipeline cleared.
- `start` high in cycle 0 (IDLE) gives:
  - first issue (`mem_rd_en`/`mem_addr`) in cycle 1;
  - RAM data in cycle 2;
  - first `dout_vld` in cycle 3.
- Issue-to-output latency is fixed at 2 cycles for both interior and pad positions.
- With no `hold`, outputs are contiguous in cycles 3..N+2. `done` is in cycle N+2, IDLE in cycle N+3.
- The earliest accepted back-to-back `start` is in cycle N+3.
- Each `hold` cycle in RUN delays the rest of the frame by exactly 1 cycle.
- `rst` mid-frame: at the next edge all outputs and state return to reset values. In-flight reads are discarded and no `done` is produced.
- `rst` and `start` in the same cycle: `rst` wins and `start` is lost.
- Address arithmetic runs at ≥ addr_w bits and never exceeds img_w*img_h-1. Pad positions never touch RAM.

## Test plan
- img_w=4, img_h=3, pad=0, RAM[i]=i+1, `start` pulse in cycle 0 -> `mem_addr` 0..11 in cycles 1..12, `dout` 1..12 with `dout_vld` in cycles 3..14, `done` in cycle 14 only, `busy` high in cycles 1..14.
- Same RAM, pad=1 (6x5 frame) -> 30 contiguous outputs: row 0, row 4, col 0 and col 5 are 0; row 1 is 0,1,2,3,4,0; `mem_rd_en` asserted exactly 12 times.
- pad=0, `hold` high in cycles 3, 4 and 8 -> still 12 outputs, values 1..12 in order, `dout` unchanged during gaps, `done` in cycle 17.
- Second `start` in cycle 5 is ignored (no restart, addresses continue). A `start` in cycle 14 (the `done` cycle) is ignored; a `start` in cycle 15 starts a new frame with first `dout_vld` in cycle 18.
- `rst` high in cycle 6 -> from cycle 7 all outputs are 0 and `done` never pulses. A fresh `start` afterwards streams 1..12 from address 0.
- img_w=img_h=28, pad=0, RAM[i]=i mod 256 -> 784 outputs, last `mem_addr`=783, `done` coincident with output 783.
